msk_rnd_feed: RTL and testbench
===============================

// Module: msk_rnd_feed
// PURPOSE
// - Supplies fresh randomness to the masked HPC2 gadgets (AND/OR, d shares).
// - Each gadget consumes d*(d-1)/2 random bits per cycle.
// - Sits directly upstream of a gadget bank, driving its rnd bus. Output is
//   RND_W bits from NLANE 32-bit Galois LFSRs. Each lane is stepped 32 times
//   per output word so consecutive words share no shifted bits.
// - Seeds are loaded through a valid/ready port, followed by a warm-up phase.
//   Stall/advance uses a valid/ready handshake.
// PARAMETERS
// d         2   number of shares per masked bit
// NGADGET   1   number of gadgets fed in parallel
// WARM_CYC  4   warm-up cycles after seeding (0 = none)
// RND_W     derived localparam = NGADGET*d*(d-1)/2 (>=1)
// NLANE     derived localparam = ceil(RND_W/32)
// PORTS
// clk         in   1      clock, all state changes on rising edge
// rst         in   1      synchronous, active-high reset
// seed_data   in   32     seed word for the lane selected by the internal index
// seed_valid  in   1      seed_data valid
// seed_ready  out  1      block accepts a seed word (high only in LOAD)
// reseed      in   1      one-cycle request to discard state and reload seeds
// rnd_out     out  RND_W  random bits: low RND_W bits of {lane[NLANE-1],...,lane[0]}
// rnd_valid   out  1      rnd_out holds an unconsumed fresh word (high only in RUN)
// rnd_ready   in   1      consumer takes rnd_out this cycle
// BEHAVIOUR
// - Reset: state=LOAD, lane index=0, all lanes=32'h1, warm counter=0.
//   Outputs: rnd_valid=0, seed_ready=1, rnd_out=low RND_W bits of the all-32'h1 lane concatenation.
// - Lane step (one bit), applied 32 times combinationally per advance:
//   lsb = s[0]; s = s >> 1; if lsb then s ^= 32'hA3000000.
//   This is a maximal-length Galois polynomial (x^32+x^30+x^26+x^25+1).
// - FSM states: LOAD, WARM, RUN.
//   - LOAD: seed_ready=1. On seed_valid&seed_ready, lane[idx] <= seed_data.
//     A seed word of 0 is replaced by 32'h1 (LFSR lock-up guard). Then idx++.
//     After word idx==NLANE-1 is accepted: idx<=0; go to WARM, or to RUN if WARM_CYC==0.
//   - WARM: every cycle all lanes advance 32 steps; counter++.
//     After WARM_CYC cycles, go to RUN.
//   - RUN: rnd_valid=1, rnd_out comes straight from the lane registers.
//     On rnd_valid&rnd_ready, all lanes advance 32 steps; the new word is on rnd_out next cycle.
//     With rnd_ready low, lanes hold and rnd_out is stable. The same word is never presented twice as fresh.
// - Latency: seed accept -> RUN takes NLANE + WARM_CYC cycles. In RUN, throughput is one word per cycle.
// - reseed (any state): next state LOAD with idx=0 and warm counter=0; rnd_valid is low from the next cycle.
//   - reseed in LOAD restarts seeding at lane 0. Already-loaded lanes keep their values until overwritten.
//   - reseed together with an accepted seed word: the word is written, then idx returns to 0.
//   - reseed together with a RUN handshake: the current word counts as consumed and the lanes advance, then LOAD.
// - rst has priority over reseed and all handshakes.
// - Unused lane bits above RND_W still advance; they are never output.
// - Lane registers are never exposed during LOAD/WARM except as a stable rnd_out with rnd_valid=0.
//   Consumers must ignore rnd_out unless rnd_valid=1.
// TESTING
// - Reset, NGADGET=1,d=2 (RND_W=1,NLANE=1): seed 32'h00000001 with WARM_CYC=0.
//   -> seed_ready drops and rnd_valid=1 the cycle after the accept.
//   -> The rnd_out sequence under continuous rnd_ready matches a bit-exact Galois model for 1000 words.
// - Seed word 0 -> lane loads 32'h1. Output is identical to the seed-1 run, never stuck at 0.
// - d=3, NGADGET=12 (RND_W=36, NLANE=2), WARM_CYC=4: two seed words with a 3-cycle gap between them.
//   -> rnd_valid rises exactly 4 cycles after the 2nd accept.
//   -> Words match the model, with lane0 in bits[31:0] and lane1 bits[3:0] in bits[35:32].
// - In RUN, hold rnd_ready=0 for 10 cycles -> rnd_out constant.
//   Then pulse rnd_ready for 1 cycle -> exactly one advance.
// - Pulse reseed mid-RUN with rnd_ready=1 -> rnd_valid=0 next cycle, seed_ready=1.
//   New seeds restart the model sequence from the new seed.
// - Assert rst during WARM and during LOAD with 1 of 2 words accepted.
//   -> State returns to LOAD, idx=0, rnd_valid=0, and the next accepted word goes to lane 0.

Source files
------------

// File: rtl/msk_rnd_feed.sv
// Randomness feeder for a bank of masked HPC2 gadgets.
// NLANE 32-bit Galois LFSRs are seeded over a valid/ready port, warmed up,
// then stepped 32 bits per consumed word so consecutive words never overlap.

// One lane advance: 32 Galois steps of x^32+x^30+x^26+x^25+1, purely combinational.
module msk_rnd_lane (
    input  logic [31:0] s_i,
    output logic [31:0] s_o
);
    // Unrolled 32-step shift; each step folds the dropped lsb back through the taps.
    always_comb begin
        s_o = s_i;
        for (int i = 0; i < 32; i++) begin
            s_o = s_o[0] ? ((s_o >> 1) ^ 32'hA300_0000) : (s_o >> 1);
        end
    end
endmodule

module msk_rnd_feed #(
    parameter int d        = 2,
    parameter int NGADGET  = 1,
    parameter int WARM_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         seed_data,
    input  logic                seed_valid,
    output logic                seed_ready,
    input  logic                reseed,
    output logic [NGADGET*d*(d-1)/2-1:0] rnd_out,
    output logic                rnd_valid,
    input  logic                rnd_ready
);
    localparam int RND_W = NGADGET * d * (d - 1) / 2;
    localparam int NLANE = (RND_W + 31) / 32;
    localparam int IDX_W = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int CNT_W = (WARM_CYC > 0) ? $clog2(WARM_CYC + 1) : 1;

    typedef enum logic [1:0] {LOAD, WARM, RUN} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NLANE-1:0][31:0]       lane_q, lane_d, lane_adv;
    logic [NLANE*32-1:0]          lane_flat;

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        msk_rnd_lane u_lane (
            .s_i (lane_q[g]),
            .s_o (lane_adv[g])
        );
    end

    // Output word is taken straight from the lane registers; upper lane bits stay hidden.
    assign lane_flat = lane_q;
    assign rnd_out   = lane_flat[RND_W-1:0];

    // Next-state, lane update and handshake outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        case (state_q)
            LOAD: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    for (int l = 0; l < NLANE; l++) begin
                        // A zero seed would lock the LFSR at zero forever.
                        if (idx_q == IDX_W'(l))
                            lane_d[l] = (seed_data == 32'h0) ? 32'h1 : seed_data;
                    end
                    if (idx_q == IDX_W'(NLANE - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = (WARM_CYC == 0) ? RUN : WARM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WARM: begin
                lane_d = lane_adv;
                if (cnt_q == CNT_W'(WARM_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                rnd_valid = 1'b1;
                if (rnd_ready) lane_d = lane_adv;
            end
            default: state_d = LOAD;
        endcase
        // Reseed wins over the state transition but not over a write or advance already made.
        if (reseed) begin
            state_d = LOAD;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    // State registers with synchronous reset; lanes restart from the non-zero value 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= {NLANE{32'h1}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
        end
    end
endmodule

// File: tb/tb_msk_rnd_feed.sv
// Bench for msk_rnd_feed: a 1-bit/1-lane instance without warm-up and a
// 36-bit/2-lane instance with 4 warm-up cycles, checked against a Galois model.
module tb_msk_rnd_feed;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    // Instance A: d=2, NGADGET=1, WARM_CYC=0
    logic [31:0] a_sd;
    logic        a_sv, a_sr, a_rs, a_rv, a_rr;
    logic [0:0]  a_out;
    // Instance B: d=3, NGADGET=12, WARM_CYC=4
    logic [31:0] b_sd;
    logic        b_sv, b_sr, b_rs, b_rv, b_rr;
    logic [35:0] b_out;

    msk_rnd_feed #(.d(2), .NGADGET(1), .WARM_CYC(0)) u_a (
        .clk(clk), .rst(rst), .seed_data(a_sd), .seed_valid(a_sv), .seed_ready(a_sr),
        .reseed(a_rs), .rnd_out(a_out), .rnd_valid(a_rv), .rnd_ready(a_rr));

    msk_rnd_feed #(.d(3), .NGADGET(12), .WARM_CYC(4)) u_b (
        .clk(clk), .rst(rst), .seed_data(b_sd), .seed_valid(b_sv), .seed_ready(b_sr),
        .reseed(b_rs), .rnd_out(b_out), .rnd_valid(b_rv), .rnd_ready(b_rr));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR: feedback mask built from the polynomial exponents {32,30,26,25}.
    function automatic logic [31:0] step32(input logic [31:0] s);
        logic [31:0] mask;
        int          ex[4] = '{32, 30, 26, 25};
        mask = '0;
        foreach (ex[k]) mask = mask | (32'h1 << (ex[k] - 1));
        for (int n = 0; n < 32; n++) begin
            if (s % 2 == 1) s = (s / 2) ^ mask;
            else            s = s / 2;
        end
        return s;
    endfunction

    function automatic logic [31:0] fix0(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // Model of instance B: the two lane values.
    logic [31:0] m0, m1;
    function automatic logic [63:0] bword();
        return {28'h0, m1[3:0], m0};
    endfunction

    // Load two seeds into B with a gap, mirror the warm-up in the model and
    // check that valid rises exactly 4 cycles after the second accept.
    task automatic b_seed(input logic [31:0] s0, input logic [31:0] s1, input int gap);
        b_sv = 1'b1; b_sd = s0; tick();
        b_sv = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("b_gap_seed_ready", 64'(b_sr), 64'h1);
            chk("b_gap_valid_low",  64'(b_rv), 64'h0);
        end
        b_sv = 1'b1; b_sd = s1; tick();
        b_sv = 1'b0;
        chk("b_accept_ready_low", 64'(b_sr), 64'h0);
        chk("b_accept_valid_low", 64'(b_rv), 64'h0);
        m0 = fix0(s0);
        m1 = fix0(s1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("b_warm_valid", 64'(b_rv), (c == 4) ? 64'h1 : 64'h0);
            m0 = step32(m0);
            m1 = step32(m1);
        end
        chk("b_first_word", 64'(b_out), bword());
    endtask

    // Random rnd_ready run on B against the model.
    task automatic b_rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            b_rr = 1'($urandom_range(0, 1));
            chk("b_run_valid", 64'(b_rv), 64'h1);
            chk("b_run_word",  64'(b_out), bword());
            tick();
            if (b_rr) begin
                m0 = step32(m0);
                m1 = step32(m1);
            end
        end
        b_rr = 1'b0;
    endtask

    typedef struct {
        logic [31:0] seed;
        int          nw;
        logic        exp0;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [31:0] ma;
        // {seed, words to check, expected first rnd_out bit}
        tbl[0] = '{32'h0000_0001, 1000, 1'b1};
        tbl[1] = '{32'h0000_0000, 1000, 1'b1};
        tbl[2] = '{32'h0000_0002,   50, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF,   50, 1'b1};

        rst = 1'b1;
        a_sd = '0; a_sv = 0; a_rs = 0; a_rr = 0;
        b_sd = '0; b_sv = 0; b_rs = 0; b_rr = 0;
        tick(); tick();
        rst = 1'b0;

        chk("a_rst_seed_ready", 64'(a_sr), 64'h1);
        chk("a_rst_valid",      64'(a_rv), 64'h0);
        chk("a_rst_out",        64'(a_out), 64'h1);
        chk("b_rst_seed_ready", 64'(b_sr), 64'h1);
        chk("b_rst_valid",      64'(b_rv), 64'h0);
        chk("b_rst_out",        64'(b_out), 64'h1_0000_0001);

        // Table-driven single-lane runs, each ended by a reseed during a handshake.
        for (int i = 0; i < 4; i++) begin
            a_sv = 1'b1; a_sd = tbl[i].seed; tick();
            a_sv = 1'b0;
            chk("a_accept_ready_low", 64'(a_sr), 64'h0);
            chk("a_accept_valid",     64'(a_rv), 64'h1);
            chk("a_first_bit",        64'(a_out), 64'(tbl[i].exp0));
            ma = fix0(tbl[i].seed);
            a_rr = 1'b1;
            for (int w = 0; w < tbl[i].nw; w++) begin
                if (a_out !== ma[0]) chk("a_seq_word", 64'(a_out), 64'(ma[0]));
                else n_tests++;
                tick();
                ma = step32(ma);
            end
            a_rs = 1'b1; tick();
            a_rs = 1'b0; a_rr = 1'b0;
            chk("a_reseed_valid_low", 64'(a_rv), 64'h0);
            chk("a_reseed_ready",     64'(a_sr), 64'h1);
        end

        // Two-lane load with a 3-cycle gap, then random consumption.
        b_seed($urandom, $urandom, 3);
        b_rand_run(300);

        // Stall: 10 cycles with rnd_ready low, then exactly one advance.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b_hold_word",  64'(b_out), bword());
            chk("b_hold_valid", 64'(b_rv), 64'h1);
        end
        b_rr = 1'b1; tick(); b_rr = 1'b0;
        m0 = step32(m0); m1 = step32(m1);
        chk("b_pulse_word", 64'(b_out), bword());
        tick();
        chk("b_pulse_once", 64'(b_out), bword());

        // Reseed mid-RUN while consuming; restart from new seeds, one of them zero.
        b_rr = 1'b1; b_rs = 1'b1; tick();
        b_rs = 1'b0; b_rr = 1'b0;
        chk("b_reseed_valid_low", 64'(b_rv), 64'h0);
        chk("b_reseed_ready",     64'(b_sr), 64'h1);
        b_seed(32'h0, $urandom, 0);
        b_rand_run(50);

        // Reset during WARM.
        b_rs = 1'b1; tick(); b_rs = 1'b0;
        b_sv = 1'b1; b_sd = $urandom; tick();
        b_sd = $urandom; tick();
        b_sv = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("b_rstwarm_ready", 64'(b_sr), 64'h1);
        chk("b_rstwarm_valid", 64'(b_rv), 64'h0);
        chk("b_rstwarm_out",   64'(b_out), 64'h1_0000_0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_rstwarm_stays_load", 64'(b_rv), 64'h0);
        end

        // Reset with one of two words accepted; the next word must land in lane 0.
        b_sv = 1'b1; b_sd = 32'hDEAD_BEEF; tick(); b_sv = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("b_rstload_ready", 64'(b_sr), 64'h1);
        chk("b_rstload_valid", 64'(b_rv), 64'h0);
        chk("b_rstload_out",   64'(b_out), 64'h1_0000_0001);
        b_seed($urandom, $urandom, 1);
        b_rand_run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
